// File: rtl/pipe_stage_skid_if.sv
// One side of a pipeline-stage handshake: instruction word, PC+4 and packed generic fields.
// A transfer happens on a rising edge where valid and ready are both 1; the master holds its payload stable while valid=1 and ready=0.
interface pipe_stage_skid_if #(
  parameter int DATA_W  = 32,
  parameter int NFIELDS = 3
);
  logic                      valid;
  logic                      ready;
  logic [31:0]               ir;
  logic [31:0]               pc4;
  logic [NFIELDS*DATA_W-1:0] data;

  modport master (output valid, ir, pc4, data, input  ready);
  modport slave  (input  valid, ir, pc4, data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic MIPS pipeline-stage register: main entry drives the outputs, a skid entry absorbs one
// extra instruction so in_ready can come straight from a flop. Flush inserts a NOP bubble.
module pipe_stage_skid #(
  parameter int          DATA_W    = 32,
  parameter int          NFIELDS   = 3,
  parameter logic [31:0] RESET_PC4 = 32'h3000,
  parameter int          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  pipe_stage_skid_if.slave   in_bus,
  pipe_stage_skid_if.master  out_bus,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);
  localparam int FW = NFIELDS * DATA_W;

  typedef struct packed {
    logic [31:0]   ir;
    logic [31:0]   pc4;
    logic [FW-1:0] data;
  } entry_t;

  logic   main_valid, main_valid_n;
  entry_t main_q, main_n;
  logic   skid_valid, skid_valid_n;
  entry_t skid_q, skid_n;
  logic   in_ready_q;
  logic   in_fire, out_fire;
  entry_t in_ent;

  assign in_fire  = in_bus.valid & in_ready_q;
  assign out_fire = main_valid & out_bus.ready;
  assign in_ent   = '{ir: in_bus.ir, pc4: in_bus.pc4, data: in_bus.data};

  always_comb begin
    main_valid_n = main_valid;
    main_n       = main_q;
    skid_valid_n = skid_valid;
    skid_n       = skid_q;
    if (flush) begin
      main_valid_n = 1'b0;
      main_n.ir    = '0;
      main_n.pc4   = '0;
      skid_valid_n = 1'b0;
    end else if (!main_valid) begin
      if (in_fire) begin
        main_valid_n = 1'b1;
        main_n       = in_ent;
      end
    end else if (out_fire) begin
      // The skid holds the older instruction, so it always refills main before new input.
      if (skid_valid) begin
        main_n       = skid_q;
        skid_valid_n = 1'b0;
      end else if (in_fire) begin
        main_n = in_ent;
      end else begin
        main_valid_n = 1'b0;
        main_n.ir    = '0;
        main_n.pc4   = '0;
      end
    end else if (in_fire) begin
      skid_valid_n = 1'b1;
      skid_n       = in_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_q     <= '{ir: '0, pc4: RESET_PC4, data: '0};
      skid_valid <= 1'b0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      main_valid <= main_valid_n;
      main_q     <= main_n;
      skid_valid <= skid_valid_n;
      skid_q     <= skid_n;
      in_ready_q <= !skid_valid_n;
      if (main_valid && !out_bus.ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!main_valid && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign in_bus.ready  = in_ready_q;
  assign out_bus.valid = main_valid;
  assign out_bus.ir    = main_q.ir;
  assign out_bus.pc4   = main_q.pc4;
  assign out_bus.data  = main_q.data;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus a randomized run checked each cycle
// against a two-deep in-order queue model of the stage.
module tb_pipe_stage_skid;
  localparam int DW = 32;
  localparam int NF = 3;
  localparam int FW = DW * NF;
  localparam int EW = 64 + FW;

  logic clk = 1'b0;
  logic reset, flush, reset_sat;
  always #5 clk = ~clk;

  pipe_stage_skid_if #(.DATA_W(DW), .NFIELDS(NF)) in_bus ();
  pipe_stage_skid_if #(.DATA_W(DW), .NFIELDS(NF)) out_bus ();
  pipe_stage_skid_if #(.DATA_W(DW), .NFIELDS(NF)) sat_in ();
  pipe_stage_skid_if #(.DATA_W(DW), .NFIELDS(NF)) sat_out ();

  logic [15:0] stall_cnt, bubble_cnt;
  logic [3:0]  sat_stall, sat_bubble;

  pipe_stage_skid #(.DATA_W(DW), .NFIELDS(NF), .RESET_PC4(32'h3000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_bus(in_bus), .out_bus(out_bus),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_skid #(.DATA_W(DW), .NFIELDS(NF), .RESET_PC4(32'h3000), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset_sat), .flush(1'b0), .in_bus(sat_in), .out_bus(sat_out),
    .stall_cnt(sat_stall), .bubble_cnt(sat_bubble)
  );

  // Reference model: in-order queue of held entries {ir, pc4, data}, at most two deep.
  logic [EW-1:0] exp_q[$];
  logic [31:0]   m_empty_pc4;
  logic [FW-1:0] m_last_data;
  logic [15:0]   m_stall, m_bubble;
  int errors = 0;
  int checks = 0;

  function automatic logic e_valid();
    return exp_q.size() != 0;
  endfunction
  function automatic logic e_ready();
    return exp_q.size() < 2;
  endfunction
  function automatic logic [31:0] e_ir();
    return (exp_q.size() != 0) ? exp_q[0][EW-1 -: 32] : 32'h0;
  endfunction
  function automatic logic [31:0] e_pc4();
    return (exp_q.size() != 0) ? exp_q[0][FW +: 32] : m_empty_pc4;
  endfunction
  function automatic logic [FW-1:0] e_data();
    return (exp_q.size() != 0) ? exp_q[0][FW-1:0] : m_last_data;
  endfunction

  task automatic tick();
    logic of, inf;
    if (reset) begin
      exp_q.delete();
      m_empty_pc4 = 32'h3000;
      m_last_data = '0;
      m_stall     = '0;
      m_bubble    = '0;
    end else begin
      if (exp_q.size() != 0 && !out_bus.ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (exp_q.size() == 0 && m_bubble != 16'hFFFF) m_bubble = m_bubble + 16'd1;
      if (flush) begin
        exp_q.delete();
        m_empty_pc4 = '0;
      end else begin
        of  = (exp_q.size() != 0) && out_bus.ready;
        inf = in_bus.valid && (exp_q.size() < 2);
        if (of) begin
          void'(exp_q.pop_front());
          m_empty_pc4 = '0;
        end
        if (inf) exp_q.push_back({in_bus.ir, in_bus.pc4, in_bus.data});
      end
      if (exp_q.size() != 0) m_last_data = exp_q[0][FW-1:0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic rdy);
    in_bus.valid  = v;
    in_bus.ir     = ir;
    in_bus.pc4    = $urandom;
    in_bus.data   = {$urandom, $urandom, $urandom};
    out_bus.ready = rdy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    checks++; if (out_bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", out_bus.valid); end
    checks++; if (out_bus.ir !== 32'h0) begin errors++; $display("FAIL reset_ir got=%h want=0", out_bus.ir); end
    checks++; if (out_bus.pc4 !== 32'h3000) begin errors++; $display("FAIL reset_pc4 got=%h want=3000", out_bus.pc4); end
    checks++; if (out_bus.data !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", out_bus.data); end
    checks++; if (in_bus.ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b want=1", in_bus.ready); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d want=0", stall_cnt); end
    checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_bubble got=%0d want=0", bubble_cnt); end
  endtask

  task automatic test_streaming();
    logic [31:0] irs[3];
    logic [31:0] pc4_sent;
    irs[0] = 32'h8C010004; irs[1] = 32'h00221820; irs[2] = 32'hAC030008;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, irs[i], 1'b1);
      pc4_sent = in_bus.pc4;
      tick();
      checks++; if (out_bus.valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%0b want=1", i, out_bus.valid); end
      checks++; if (out_bus.ir !== irs[i]) begin errors++; $display("FAIL stream_ir[%0d] got=%h want=%h", i, out_bus.ir, irs[i]); end
      checks++; if (out_bus.pc4 !== pc4_sent) begin errors++; $display("FAIL stream_pc4[%0d] got=%h want=%h", i, out_bus.pc4, pc4_sent); end
      checks++; if (in_bus.ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got=%0b want=1", i, in_bus.ready); end
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    checks++; if (out_bus.valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got=%0b want=0", out_bus.valid); end
    checks++; if (out_bus.ir !== 32'h0) begin errors++; $display("FAIL stream_drain_ir got=%h want=0", out_bus.ir); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'h11111111, 1'b0);
    tick();
    checks++; if (out_bus.ir !== 32'h11111111) begin errors++; $display("FAIL bp_a_ir got=%h want=11111111", out_bus.ir); end
    checks++; if (in_bus.ready !== 1'b1) begin errors++; $display("FAIL bp_a_in_ready got=%0b want=1", in_bus.ready); end
    drive(1'b1, 32'h22222222, 1'b0);
    tick();
    checks++; if (out_bus.ir !== 32'h11111111) begin errors++; $display("FAIL bp_b_ir got=%h want=11111111", out_bus.ir); end
    checks++; if (in_bus.ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got=%0b want=0", in_bus.ready); end
    drive(1'b1, 32'h33333333, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (stall_cnt !== m_stall) begin errors++; $display("FAIL bp_stall[%0d] got=%0d want=%0d", i, stall_cnt, m_stall); end
      checks++; if (out_bus.ir !== 32'h11111111 || in_bus.ready !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d] got ir=%h rdy=%0b want ir=11111111 rdy=0", i, out_bus.ir, in_bus.ready); end
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    checks++; if (out_bus.ir !== 32'h22222222) begin errors++; $display("FAIL bp_release_ir got=%h want=22222222", out_bus.ir); end
    checks++; if (in_bus.ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%0b want=1", in_bus.ready); end
    tick();
    checks++; if (out_bus.valid !== 1'b0) begin errors++; $display("FAIL bp_empty_valid got=%0b want=0", out_bus.valid); end
  endtask

  task automatic test_flush_full();
    logic [FW-1:0] data_a;
    drive(1'b1, 32'hAAAA0001, 1'b0);
    data_a = in_bus.data;
    tick();
    drive(1'b1, 32'hBBBB0002, 1'b0);
    tick();
    checks++; if (in_bus.ready !== 1'b0) begin errors++; $display("FAIL flush_pre_in_ready got=%0b want=0", in_bus.ready); end
    drive(1'b0, 32'h0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (out_bus.valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b want=0", out_bus.valid); end
    checks++; if (out_bus.ir !== 32'h0) begin errors++; $display("FAIL flush_ir got=%h want=0", out_bus.ir); end
    checks++; if (out_bus.pc4 !== 32'h0) begin errors++; $display("FAIL flush_pc4 got=%h want=0", out_bus.pc4); end
    checks++; if (out_bus.data !== data_a) begin errors++; $display("FAIL flush_data got=%h want=%h", out_bus.data, data_a); end
    checks++; if (in_bus.ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%0b want=1", in_bus.ready); end
    out_bus.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_bus.valid !== 1'b0 || out_bus.ir === 32'hBBBB0002) begin errors++; $display("FAIL flush_no_b[%0d] got valid=%0b ir=%h want valid=0", i, out_bus.valid, out_bus.ir); end
    end
  endtask

  task automatic test_flush_with_input();
    drive(1'b1, 32'hCCCC0003, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    checks++; if (out_bus.valid !== 1'b0) begin errors++; $display("FAIL flush_in_valid got=%0b want=0", out_bus.valid); end
    checks++; if (in_bus.ready !== 1'b1) begin errors++; $display("FAIL flush_in_in_ready got=%0b want=1", in_bus.ready); end
    tick();
    checks++; if (out_bus.valid !== 1'b0) begin errors++; $display("FAIL flush_in_dropped got=%0b want=0", out_bus.valid); end
  endtask

  task automatic test_random();
    logic [EW+50:0] got, want;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 31) == 0);
      drive(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0));
      tick();
      got  = {out_bus.valid, in_bus.ready, out_bus.ir, out_bus.pc4, out_bus.data, stall_cnt, bubble_cnt};
      want = {e_valid(), e_ready(), e_ir(), e_pc4(), e_data(), m_stall, m_bubble};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random[%0d] got v=%0b r=%0b ir=%h pc4=%h st=%0d bu=%0d want v=%0b r=%0b ir=%h pc4=%h st=%0d bu=%0d",
                 i, out_bus.valid, in_bus.ready, out_bus.ir, out_bus.pc4, stall_cnt, bubble_cnt,
                 e_valid(), e_ready(), e_ir(), e_pc4(), m_stall, m_bubble);
      end
    end
    reset = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_saturation();
    reset_sat = 1'b1;
    tick();
    reset_sat = 1'b0;
    checks++; if (sat_bubble !== 4'd0) begin errors++; $display("FAIL sat_start got=%0d want=0", sat_bubble); end
    repeat (10) tick();
    checks++; if (sat_bubble !== 4'd10) begin errors++; $display("FAIL sat_mid got=%0d want=10", sat_bubble); end
    repeat (10) tick();
    checks++; if (sat_bubble !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d want=15", sat_bubble); end
    checks++; if (sat_stall !== 4'd0) begin errors++; $display("FAIL sat_stall got=%0d want=0", sat_stall); end
    reset_sat = 1'b1;
    tick();
    reset_sat = 1'b0;
    checks++; if (sat_bubble !== 4'd0) begin errors++; $display("FAIL sat_reset got=%0d want=0", sat_bubble); end
  endtask

  initial begin
    reset         = 1'b1;
    reset_sat     = 1'b1;
    flush         = 1'b0;
    sat_in.valid  = 1'b0;
    sat_in.ir     = '0;
    sat_in.pc4    = '0;
    sat_in.data   = '0;
    sat_out.ready = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_flush_with_input();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
